// File: rtl/seg_scan_driver.sv
// Multiplexed multi-digit 7-segment driver.
// A double-buffered display register feeds a time-multiplexed scan. Each digit
// owns SCAN_DIV cycles, the first BLANK_CYC of which keep every anode off to
// stop ghosting. New values are staged in a pending buffer and copied to the
// display buffer only at the frame boundary, so a frame never shows a mix of
// old and new digits.

// Per-digit glyph decode. The glyph is produced in active-low form; the top
// level applies the output polarity once, after digit selection.
module seg_scan_lane (
    input  logic [3:0] nib,
    output logic [6:0] glyph,
    output logic       is_zero
);

    // Hex nibble to gfedcba pattern (0 = segment lit)
    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
            default: glyph = 7'h7F;
        endcase
    end

    assign is_zero = (nib == 4'h0);

endmodule

module seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Output levels for "dark"; seg/dp polarity and anode polarity are independent
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] nib;
        logic [NUM_DIGITS-1:0]      dp;
    } disp_buf_t;

    disp_buf_t        pending;
    disp_buf_t        display;
    logic [CNT_W-1:0] div_cnt;
    logic [IDX_W-1:0] digit_idx;

    logic slot_end;
    logic frame_end;
    logic lit_win;
    logic lit;

    logic [NUM_DIGITS-1:0][6:0] glyph;
    logic [NUM_DIGITS-1:0]      nib_zero;
    logic [NUM_DIGITS-1:0]      suppress;
    logic                       zero_run;

    logic [6:0]            seg_al;
    logic                  dp_al;
    logic [NUM_DIGITS-1:0] an_hot;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    assign slot_end  = (div_cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end = slot_end && (digit_idx == IDX_W'(NUM_DIGITS - 1));

    // With no blank time every slot position is a lit position
    generate
        if (BLANK_CYC == 0) begin : g_no_gap
            assign lit_win = 1'b1;
        end else begin : g_gap
            assign lit_win = (div_cnt >= CNT_W'(BLANK_CYC));
        end
    endgenerate

    assign lit = lit_win && !blank;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
            seg_scan_lane u_lane (
                .nib     (display.nib[g]),
                .glyph   (glyph[g]),
                .is_zero (nib_zero[g])
            );
        end
    endgenerate

    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 always shows so a zero value still reads "0"
    always_comb begin
        zero_run = 1'b1;
        suppress = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run & nib_zero[i];
            suppress[i] = lz_en & zero_run & (i != 0);
        end
    end

    // Next output values for the current slot, built in active-low form first
    always_comb begin
        an_hot = '0;
        seg_al = 7'h7F;
        dp_al  = 1'b1;
        if (lit) begin
            an_hot[digit_idx] = 1'b1;
            seg_al = suppress[digit_idx] ? 7'h7F : glyph[digit_idx];
            dp_al  = ~display.dp[digit_idx];
        end
        seg_nxt = (SEG_ACTIVE_LOW != 0) ? seg_al : ~seg_al;
        dp_nxt  = (SEG_ACTIVE_LOW != 0) ? dp_al  : ~dp_al;
        an_nxt  = (AN_ACTIVE_LOW  != 0) ? ~an_hot : an_hot;
    end

    // Scan counters and the two display buffers; swap only at the frame boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= '0;
            display   <= '0;
            div_cnt   <= '0;
            digit_idx <= '0;
        end else begin
            if (load)
                pending <= {value, dp_in};
            if (frame_end)
                display <= pending;
            if (slot_end) begin
                div_cnt   <= '0;
                digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Registered pin drivers, one cycle behind the scan state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            dp_out     <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            dp_out     <= dp_nxt;
            an         <= an_nxt;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: table of static display patterns, hand-written
// multi-cycle corner cases, and a randomized run checked every cycle against
// a time-based reference model.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FR = SD * ND;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_en;
    logic        blank;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    seg_scan_driver #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (SD),
        .BLANK_CYC      (BC),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .lz_en      (lz_en),
        .blank      (blank),
        .seg        (seg),
        .dp_out     (dp_out),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] gly [16];

    // Reference model: time since reset, plus the two buffers as plain words
    int          mt = 0;
    logic [15:0] m_pend_v  = '0;
    logic [15:0] m_disp_v  = '0;
    logic [3:0]  m_pend_dp = '0;
    logic [3:0]  m_disp_dp = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // One clock: predict outputs from the model, advance both, compare
    task automatic step();
        logic [6:0] es;
        logic       ed;
        logic [3:0] ea;
        logic       ef;
        logic       lit;
        logic       supp;
        logic [3:0] nib;
        int         slot;
        int         pos;
        es = 7'h7F; ed = 1'b1; ea = 4'hF; ef = 1'b0;
        if (rst_n) begin
            slot = (mt / SD) % ND;
            pos  = mt % SD;
            lit  = (pos >= BC) && !blank;
            nib  = 4'((m_disp_v >> (4 * slot)) & 16'hF);
            supp = lz_en && (slot >= 1) && ((m_disp_v >> (4 * slot)) == 16'h0);
            if (lit) begin
                es = supp ? 7'h7F : gly[nib];
                ed = !m_disp_dp[slot];
                ea = ~(4'b0001 << slot);
            end
            ef = ((mt % FR) == FR - 1);
        end
        @(posedge clk);
        if (!rst_n) begin
            mt = 0; m_pend_v = '0; m_disp_v = '0; m_pend_dp = '0; m_disp_dp = '0;
        end else begin
            if ((mt % FR) == FR - 1) begin
                m_disp_v  = m_pend_v;
                m_disp_dp = m_pend_dp;
            end
            if (load) begin
                m_pend_v  = value;
                m_pend_dp = dp_in;
            end
            mt++;
        end
        #1;
        chk("model{seg,dp,an,fd}", {19'b0, seg, dp_out, an, frame_done}, {19'b0, es, ed, ea, ef});
    endtask

    // Step until the model's frame position reaches m
    task automatic align(input int m);
        int n = 0;
        while ((mt % FR) != m && n < 2 * FR) begin
            step();
            n++;
        end
    endtask

    task automatic wait_an(input logic [3:0] target, input string nm);
        int n = 0;
        while (an !== target && n < 3 * FR) begin
            step();
            n++;
        end
        chk(nm, {28'b0, an}, {28'b0, target});
    endtask

    typedef struct packed {
        logic [15:0]     v;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0][6:0] eseg;
        logic [3:0]      edp;
    } vec_t;

    vec_t tab [6];

    initial begin
        int         lit_cnt;
        int         per;
        int         n;
        logic [3:0] one;

        gly[0]  = 7'b1000000; gly[1]  = 7'b1111001; gly[2]  = 7'b0100100; gly[3]  = 7'b0110000;
        gly[4]  = 7'b0011001; gly[5]  = 7'b0010010; gly[6]  = 7'b0000010; gly[7]  = 7'b1111000;
        gly[8]  = 7'b0000000; gly[9]  = 7'b0010000; gly[10] = 7'b0001000; gly[11] = 7'b0000011;
        gly[12] = 7'b1000110; gly[13] = 7'b0100001; gly[14] = 7'b0000110; gly[15] = 7'b0001110;

        // eseg is {digit3, digit2, digit1, digit0}; edp is active-low per digit
        tab[0] = '{v: 16'h1234, dp: 4'b0000, lz: 1'b0,
                   eseg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, edp: 4'b1111};
        tab[1] = '{v: 16'h0070, dp: 4'b0000, lz: 1'b1,
                   eseg: {7'h7F, 7'h7F, 7'b1111000, 7'b1000000}, edp: 4'b1111};
        tab[2] = '{v: 16'h0000, dp: 4'b0000, lz: 1'b1,
                   eseg: {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, edp: 4'b1111};
        tab[3] = '{v: 16'h0000, dp: 4'b0000, lz: 1'b0,
                   eseg: {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, edp: 4'b1111};
        tab[4] = '{v: 16'h89EF, dp: 4'b0100, lz: 1'b0,
                   eseg: {7'b0000000, 7'b0010000, 7'b0000110, 7'b0001110}, edp: 4'b1011};
        tab[5] = '{v: 16'h0070, dp: 4'b1000, lz: 1'b1,
                   eseg: {7'h7F, 7'h7F, 7'b1111000, 7'b1000000}, edp: 4'b0111};

        rst_n = 1'b0; value = '0; dp_in = '0; load = 1'b0; lz_en = 1'b0; blank = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_seg", {25'b0, seg}, 32'h7F);
        chk("rst_an", {28'b0, an}, 32'hF);
        chk("rst_dp", {31'b0, dp_out}, 32'h1);
        chk("rst_fd", {31'b0, frame_done}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("release_blank_an", {28'b0, an}, 32'hF);
        step();
        chk("first_an", {28'b0, an}, 32'hE);
        chk("first_seg_zero", {25'b0, seg}, 32'h40);

        // Static patterns: one full frame after the new value is on display
        for (int e = 0; e < 6; e++) begin
            value = tab[e].v; dp_in = tab[e].dp; lz_en = tab[e].lz; load = 1'b1;
            step();
            load = 1'b0;
            repeat (FR) step();
            align(0);
            lit_cnt = 0;
            repeat (FR) begin
                step();
                if (an !== 4'hF) lit_cnt++;
                for (int d = 0; d < ND; d++) begin
                    one = 4'b0001 << d;
                    if (~an == one) begin
                        chk($sformatf("vec%0d_seg_d%0d", e, d), {25'b0, seg}, {25'b0, tab[e].eseg[d]});
                        chk($sformatf("vec%0d_dp_d%0d", e, d), {31'b0, dp_out}, {31'b0, tab[e].edp[d]});
                    end
                end
            end
            chk($sformatf("vec%0d_lit_cycles", e), lit_cnt, 3 * ND);
        end

        // Tear-free: a load during digit 2 only shows from the next digit 0
        lz_en = 1'b0; dp_in = '0;
        value = 16'h1234; load = 1'b1; step(); load = 1'b0;
        repeat (2 * FR) step();
        align(8);
        value = 16'hABCD; load = 1'b1; step(); load = 1'b0;
        wait_an(4'h7, "tear_an3");
        chk("tear_old_d3", {25'b0, seg}, {25'b0, 7'b1111001});
        wait_an(4'hE, "tear_an0");
        chk("tear_new_d0", {25'b0, seg}, {25'b0, 7'b0100001});

        // Load on the boundary edge waits a whole frame
        align(FR - 1);
        value = 16'h5555; load = 1'b1; step(); load = 1'b0;
        chk("bnd_fd_pulse", {31'b0, frame_done}, 32'h1);
        wait_an(4'hE, "bnd_an0_a");
        chk("bnd_old_d0", {25'b0, seg}, {25'b0, 7'b0100001});
        n = 0;
        while (frame_done !== 1'b1 && n < 2 * FR) begin step(); n++; end
        wait_an(4'hE, "bnd_an0_b");
        chk("bnd_new_d0", {25'b0, seg}, {25'b0, 7'b0010010});

        // Blank: anodes dark, frame_done keeps its period
        blank = 1'b1;
        repeat (10) begin
            step();
            chk("blank_an", {28'b0, an}, 32'hF);
        end
        n = 0;
        while (frame_done !== 1'b1 && n < 2 * FR) begin step(); n++; end
        per = 0;
        do begin
            step();
            per++;
            chk("blank_an_frame", {28'b0, an}, 32'hF);
        end while (frame_done !== 1'b1 && per < 2 * FR);
        chk("blank_fd_period", per, FR);
        blank = 1'b0;

        // Randomized traffic including occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
            if ($urandom_range(0, 3) == 0) value = value & 16'h000F;
            dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 15) == 0) blank = ~blank;
            step();
        end
        rst_n = 1'b1; load = 1'b0; blank = 1'b0; lz_en = 1'b0;
        repeat (FR) step();

        // Reset mid-frame: outputs dark, scan restarts at digit 0 showing "0"
        value = 16'h9876; load = 1'b1; step(); load = 1'b0;
        repeat (2 * FR) step();
        align(9);
        rst_n = 1'b0;
        step();
        chk("midrst_seg", {25'b0, seg}, 32'h7F);
        chk("midrst_an", {28'b0, an}, 32'hF);
        chk("midrst_fd", {31'b0, frame_done}, 32'h0);
        rst_n = 1'b1;
        step();
        step();
        chk("midrst_an0", {28'b0, an}, 32'hE);
        chk("midrst_seg0", {25'b0, seg}, 32'h40);
        repeat (2 * FR) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
